// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 processor-port arbiter.
package l2_pkg;

    localparam int L2_ADDR_W = 28;
    localparam int L2_DATA_W = 128;
    localparam int L2_CNT_W  = 16;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/l2_port_arbiter_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the L2 processor port between the
// I-cache miss path and the D-cache miss/writeback path.
module l2_port_arbiter
    import l2_pkg::*;
#(
    parameter int ADDR_W = L2_ADDR_W,
    parameter int DATA_W = L2_DATA_W,
    parameter int CNT_W  = L2_CNT_W
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_ready,
    output logic [CNT_W-1:0]  i_stall_cnt,
    output logic [CNT_W-1:0]  d_stall_cnt
);

    arb_state_e        state;
    logic              owner;
    logic              rr_ptr;
    logic              cap_read;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              i_vld;
    logic              d_vld;
    logic              winner;
    logic              grant;
    logic              active;
    logic              done;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // read&write together is illegal and never wins a grant
    assign i_vld = i_read ^ i_write;
    assign d_vld = d_read ^ d_write;

    always_comb begin
        winner = rr_ptr;
        unique case (1'b1)
            i_vld && !d_vld: winner = PORT_I;
            d_vld && !i_vld: winner = PORT_D;
            default:         winner = rr_ptr;
        endcase
    end

    assign grant  = (state == ARB_BUSY) ? owner : winner;
    assign active = proc_reset_n &&
                    ((state == ARB_BUSY) || i_vld || d_vld);
    assign done   = active && l2_ready;

    always_comb begin
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (state == ARB_BUSY) begin
            sel_read  = cap_read;
            sel_write = cap_write;
            sel_addr  = cap_addr;
            sel_wdata = cap_wdata;
        end else if (winner == PORT_D) begin
            sel_read  = d_read;
            sel_write = d_write;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end else begin
            sel_read  = i_read;
            sel_write = i_write;
            sel_addr  = i_addr;
            sel_wdata = i_wdata;
        end
    end

    assign l2_read  = active && sel_read;
    assign l2_write = active && sel_write;
    assign l2_addr  = active ? sel_addr  : '0;
    assign l2_wdata = active ? sel_wdata : '0;

    assign i_ready = done && (grant == PORT_I);
    assign d_ready = done && (grant == PORT_D);
    assign i_rdata = i_ready ? l2_rdata : '0;
    assign d_rdata = d_ready ? l2_rdata : '0;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state     <= ARB_IDLE;
            owner     <= PORT_I;
            rr_ptr    <= PORT_I;
            cap_read  <= 1'b0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (i_vld || d_vld) begin
                        if (l2_ready) begin
                            rr_ptr <= ~winner;
                        end else begin
                            owner     <= winner;
                            cap_read  <= sel_read;
                            cap_write <= sel_write;
                            cap_addr  <= sel_addr;
                            cap_wdata <= sel_wdata;
                            state     <= ARB_BUSY;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (l2_ready) begin
                        rr_ptr <= ~owner;
                        state  <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // a port stalls on any cycle it asserts read or write without completing
    sat_counter #(.CNT_W(CNT_W)) u_i_stall (
        .clk   (clk),
        .rst_n (proc_reset_n),
        .inc   ((i_read || i_write) && !i_ready),
        .cnt   (i_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_d_stall (
        .clk   (clk),
        .rst_n (proc_reset_n),
        .inc   ((d_read || d_write) && !d_ready),
        .cnt   (d_stall_cnt)
    );

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter with a fixed-latency L2 model.
module tb_l2_port_arbiter;
    import l2_pkg::*;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          proc_reset_n = 1'b0;
    logic          i_read = 1'b0, i_write = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_wdata = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          l2_read, l2_write;
    logic [AW-1:0] l2_addr;
    logic [DW-1:0] l2_wdata;
    logic [DW-1:0] l2_rdata;
    logic          l2_ready;
    logic [CW-1:0] i_stall_cnt, d_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] lat = '0;
    logic [4:0] mcnt;
    logic       l2_req;

    l2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .i_read       (i_read),
        .i_write      (i_write),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_rdata      (i_rdata),
        .i_ready      (i_ready),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ready      (d_ready),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_addr      (l2_addr),
        .l2_wdata     (l2_wdata),
        .l2_rdata     (l2_rdata),
        .l2_ready     (l2_ready),
        .i_stall_cnt  (i_stall_cnt),
        .d_stall_cnt  (d_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        return {4{4'hA, a}};
    endfunction

    // L2 answers lat cycles after the request first appears (0 = hit)
    assign l2_req   = l2_read || l2_write;
    assign l2_ready = l2_req && (mcnt == lat);
    assign l2_rdata = line_of(l2_addr);

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n)          mcnt <= '0;
        else if (l2_req && !l2_ready) mcnt <= mcnt + 5'd1;
        else                        mcnt <= '0;
    end

    task automatic check(input string tag,
                         input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_check();
        @(negedge clk);
    endtask

    task automatic do_reset();
        to_drive();
        proc_reset_n = 1'b0;
        to_check();
        #1 proc_reset_n = 1'b1;
        to_drive();
    endtask

    initial begin
        logic exp_port;
        int   nb;

        // reset state, with a request pending on I
        i_read = 1'b1;
        i_addr = 28'h0000010;
        to_check();
        check("rst_l2_read", l2_read, 0);
        check("rst_l2_addr", l2_addr, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_i_stall", i_stall_cnt, 0);
        check("rst_d_stall", d_stall_cnt, 0);
        check("rst_state", dut.state, ARB_IDLE);
        i_read = 1'b0;
        #1 proc_reset_n = 1'b1;

        // L2 hit: zero-latency pass-through
        to_drive();
        lat    = 5'd0;
        i_read = 1'b1;
        to_check();
        check("hit_l2_read", l2_read, 1);
        check("hit_i_ready", i_ready, 1);
        check("hit_i_rdata", i_rdata, line_of(28'h0000010));
        check("hit_d_ready", d_ready, 0);
        check("hit_state", dut.state, ARB_IDLE);
        to_drive();
        i_read = 1'b0;
        to_check();
        check("hit_state_after", dut.state, ARB_IDLE);
        check("hit_i_ready_after", i_ready, 0);

        // both read from reset, latency 5
        do_reset();
        lat    = 5'd5;
        i_addr = 28'h0000100;
        d_addr = 28'h0000200;
        i_read = 1'b1;
        d_read = 1'b1;
        for (int c = 0; c < 12; c++) begin
            to_check();
            check($sformatf("lat5_addr_c%0d", c), l2_addr,
                  (c < 6) ? 28'h0000100 : 28'h0000200);
            check($sformatf("lat5_i_ready_c%0d", c), i_ready, c == 5);
            check($sformatf("lat5_d_ready_c%0d", c), d_ready, c == 11);
            if (c == 11) check("lat5_d_rdata", d_rdata, line_of(28'h0000200));
            to_drive();
            if (c == 5)  i_read = 1'b0;
            if (c == 11) d_read = 1'b0;
        end
        to_check();
        check("lat5_i_stall", i_stall_cnt, 5);
        check("lat5_d_stall", d_stall_cnt, 11);

        // D write, address changes mid-transaction
        to_drive();
        lat     = 5'd3;
        d_addr  = 28'h00000F3;
        d_wdata = 128'hABCD_EF01_2345_6789_ABCD_EF01_2345_6789;
        d_write = 1'b1;
        nb = 0;
        for (int c = 0; c < 5; c++) begin
            to_check();
            if (c < 4) begin
                check($sformatf("dw_addr_c%0d", c), l2_addr, 28'h00000F3);
                check($sformatf("dw_write_c%0d", c), l2_write, 1);
                check($sformatf("dw_wdata_c%0d", c), l2_wdata, d_wdata);
            end
            if (d_ready) nb++;
            check($sformatf("dw_d_ready_c%0d", c), d_ready, c == 3);
            to_drive();
            if (c == 0) d_addr = 28'h0000001;
            if (c == 3) d_write = 1'b0;
        end
        check("dw_ready_count", nb, 1);
        check("dw_d_stall", d_stall_cnt, 14);

        // continuous contention: strict alternation I,D,I,D...
        lat    = 5'd2;
        i_addr = 28'h0000020;
        d_addr = 28'h0000030;
        i_read = 1'b1;
        d_read = 1'b1;
        for (int c = 0; c < 24; c++) begin
            to_check();
            exp_port = ((c / 3) % 2) == 1;
            check($sformatf("rr_addr_c%0d", c), l2_addr,
                  exp_port ? 28'h0000030 : 28'h0000020);
            check($sformatf("rr_i_ready_c%0d", c), i_ready,
                  (c % 3 == 2) && !exp_port);
            check($sformatf("rr_d_ready_c%0d", c), d_ready,
                  (c % 3 == 2) && exp_port);
            check($sformatf("rr_both_c%0d", c), i_ready && d_ready, 0);
            to_drive();
        end
        i_read = 1'b0;
        d_read = 1'b0;
        to_check();
        check("rr_i_stall", i_stall_cnt, 25);
        check("rr_d_stall", d_stall_cnt, 34);

        // illegal read&write on I for 10 cycles
        do_reset();
        i_read  = 1'b1;
        i_write = 1'b1;
        for (int c = 0; c < 10; c++) begin
            to_check();
            check($sformatf("ill_l2_req_c%0d", c), l2_req, 0);
            check($sformatf("ill_i_ready_c%0d", c), i_ready, 0);
            to_drive();
        end
        i_read  = 1'b0;
        i_write = 1'b0;
        to_check();
        check("ill_i_stall", i_stall_cnt, 10);
        check("ill_d_stall", d_stall_cnt, 0);

        // move rr_ptr to D with an I hit, then reset mid-BUSY
        to_drive();
        lat    = 5'd0;
        i_addr = 28'h0000040;
        d_addr = 28'h0000050;
        i_read = 1'b1;
        to_check();
        check("pre_i_ready", i_ready, 1);
        to_drive();
        check("pre_rr_ptr", dut.rr_ptr, PORT_D);
        lat = 5'd10;
        to_check();
        to_drive();
        to_check();
        check("busy_l2_read", l2_read, 1);
        check("busy_state", dut.state, ARB_BUSY);
        to_drive();
        #2 proc_reset_n = 1'b0;
        #1;
        check("arst_l2_read", l2_read, 0);
        check("arst_l2_write", l2_write, 0);
        check("arst_i_stall", i_stall_cnt, 0);
        check("arst_state", dut.state, ARB_IDLE);
        to_check();
        #1;
        lat = 5'd0;
        d_read = 1'b1;
        proc_reset_n = 1'b1;
        #1;
        check("post_i_ready", i_ready, 1);
        check("post_d_ready", d_ready, 0);
        check("post_l2_addr", l2_addr, 28'h0000040);
        to_drive();
        i_read = 1'b0;
        d_read = 1'b0;
        to_check();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
